// File: rtl/token_path_animator.sv
// Player token position tracker and tile-by-tile slide animator.
// One shared move FSM drives an array of per-lane position registers.

module token_lane #(
  parameter int X_START     = 20,
  parameter int PX_PER_TICK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       step,
  input  logic       adv,
  input  logic [9:0] target,
  output logic [9:0] x,
  output logic [3:0] tile
);
  logic [10:0] sum;
  assign sum = {1'b0, x} + 11'(PX_PER_TICK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x    <= 10'(X_START);
      tile <= '0;
    end else if (sel) begin
      // saturate on the target so a non-dividing step never overshoots
      if (step) x <= (sum >= {1'b0, target}) ? target : sum[9:0];
      if (adv)  tile <= tile + 4'd1;
    end
  end
endmodule

module token_path_animator #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_TILES   = 11,
  parameter int X_START     = 20,
  parameter int X_STEP      = 60,
  parameter int Y_BASE      = 120,
  parameter int Y_LANE_STEP = 40,
  parameter int PX_PER_TICK = 4,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [PW-1:0]              move_player,
  input  logic [2:0]                 move_steps,
  output logic [NUM_PLAYERS*10-1:0]  pos_x,
  output logic [NUM_PLAYERS*10-1:0]  pos_y,
  output logic [NUM_PLAYERS*4-1:0]   tile_idx,
  output logic                       busy,
  output logic                       move_done,
  output logic                       winner_valid,
  output logic [PW-1:0]              winner_id
);
  if (X_START + X_STEP * (NUM_TILES - 1) > 1023) begin : g_xrange
    $error("token_path_animator: finish tile x exceeds 10 bits");
  end
  if (NUM_TILES < 2 || NUM_TILES > 16) begin : g_tiles
    $error("token_path_animator: NUM_TILES out of range");
  end
  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_players
    $error("token_path_animator: NUM_PLAYERS out of range");
  end
  if (PX_PER_TICK < 1) begin : g_px
    $error("token_path_animator: PX_PER_TICK must be >= 1");
  end

  localparam logic [PW:0] NP   = (PW+1)'(NUM_PLAYERS);
  localparam logic [3:0]  TMAX = 4'(NUM_TILES - 1);
  localparam logic [9:0]  XS   = 10'(X_START);
  localparam logic [9:0]  XST  = 10'(X_STEP);

  typedef enum logic [2:0] {IDLE, SETUP, SLIDE, ARRIVE, DONE} state_t;

  state_t                        state;
  logic [PW-1:0]                 player;
  logic [3:0]                    rem;
  logic [9:0]                    target;
  logic [NUM_PLAYERS-1:0][9:0]   lx;
  logic [NUM_PLAYERS-1:0][3:0]   lt;

  logic       pvalid, mv_ok, step;
  logic [9:0] cur_x;
  logic [3:0] cur_tile, mv_tile, left, rem_new;

  assign pvalid   = {1'b0, player} < NP;
  assign cur_x    = pvalid ? lx[player] : XS;
  assign cur_tile = pvalid ? lt[player] : 4'd0;
  assign mv_ok    = {1'b0, move_player} < NP;
  assign mv_tile  = mv_ok ? lt[move_player] : TMAX;
  // an out-of-range player looks like a finished token so it clamps to zero steps
  assign left     = TMAX - mv_tile;
  assign rem_new  = ({1'b0, move_steps} < left) ? {1'b0, move_steps} : left;
  assign step     = (state == SLIDE) && frame_tick && (cur_x != target);

  assign move_ready = rst_n && (state == IDLE) && !winner_valid;
  assign busy       = state != IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      player       <= '0;
      rem          <= '0;
      target       <= XS;
      move_done    <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      move_done <= 1'b0;
      case (state)
        IDLE: if (move_valid && !winner_valid) begin
          player <= move_player;
          rem    <= rem_new;
          if (rem_new != 4'd0) state <= SETUP;
          else begin
            state     <= DONE;
            move_done <= 1'b1;
          end
        end
        SETUP: begin
          target <= XS + XST * ({6'd0, cur_tile} + 10'd1);
          state  <= SLIDE;
        end
        SLIDE: if (cur_x == target) state <= ARRIVE;
        ARRIVE: begin
          rem <= rem - 4'd1;
          if (rem > 4'd1) state <= SETUP;
          else begin
            state     <= DONE;
            move_done <= 1'b1;
          end
        end
        DONE: begin
          if (pvalid && cur_tile == TMAX && !winner_valid) begin
            winner_valid <= 1'b1;
            winner_id    <= player;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    token_lane #(.X_START(X_START), .PX_PER_TICK(PX_PER_TICK)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (pvalid && player == PW'(p)),
      .step   (step),
      .adv    (state == ARRIVE),
      .target (target),
      .x      (lx[p]),
      .tile   (lt[p])
    );
    assign pos_x[p*10 +: 10]   = lx[p];
    assign pos_y[p*10 +: 10]   = 10'(Y_BASE + p * Y_LANE_STEP);
    assign tile_idx[p*4 +: 4]  = lt[p];
  end
endmodule

// File: tb/tb_token_path_animator.sv
// Randomised scoreboard bench for token_path_animator: a tile-count board model
// predicts final positions per move; a monitor compares them on every move_done.
module tb_token_path_animator;
  localparam int NP = 2, NT = 11, XS = 20, XST = 60;

  logic        clk = 0, rst_n = 0, frame_tick = 0, move_valid = 0;
  logic [0:0]  move_player = '0;
  logic [2:0]  move_steps = '0;
  logic        move_ready, busy, move_done, winner_valid;
  logic [0:0]  winner_id;
  logic [19:0] pos_x, pos_y;
  logic [7:0]  tile_idx;

  logic        t7_tick = 0, t7_valid = 0;
  logic [0:0]  t7_player = '0;
  logic [2:0]  t7_steps = '0;
  logic        t7_ready, t7_busy, t7_done, t7_wv;
  logic [0:0]  t7_wid;
  logic [19:0] t7_x, t7_y;
  logic [7:0]  t7_tile;

  token_path_animator #(.NUM_PLAYERS(2), .NUM_TILES(11), .X_START(20), .X_STEP(60),
    .Y_BASE(120), .Y_LANE_STEP(40), .PX_PER_TICK(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .move_valid(move_valid),
    .move_ready(move_ready), .move_player(move_player), .move_steps(move_steps),
    .pos_x(pos_x), .pos_y(pos_y), .tile_idx(tile_idx), .busy(busy),
    .move_done(move_done), .winner_valid(winner_valid), .winner_id(winner_id));

  token_path_animator #(.NUM_PLAYERS(2), .NUM_TILES(11), .X_START(20), .X_STEP(60),
    .Y_BASE(120), .Y_LANE_STEP(40), .PX_PER_TICK(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .frame_tick(t7_tick), .move_valid(t7_valid),
    .move_ready(t7_ready), .move_player(t7_player), .move_steps(t7_steps),
    .pos_x(t7_x), .pos_y(t7_y), .tile_idx(t7_tile), .busy(t7_busy),
    .move_done(t7_done), .winner_valid(t7_wv), .winner_id(t7_wid));

  always #5 clk = ~clk;

  typedef struct packed { logic [19:0] x; logic [7:0] t; } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0;
  int   mtile[NP];
  bit   mwin;
  int   mid;
  int   tick_mode = 0, tick_ph = 0, tick_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.x[p*10 +: 10] = 10'(XS + XST * mtile[p]);
      e.t[p*4 +: 4]   = 4'(mtile[p]);
    end
    return e;
  endfunction

  // frame tick source: 0 off, 1 random, 2 every 8 clk, 3 driven by stimulus
  initial forever begin
    @(negedge clk);
    if (tick_mode == 2) begin
      tick_ph++;
      frame_tick = (tick_ph % 8 == 0);
    end else if (tick_mode == 1) frame_tick = ($urandom_range(0, 1) == 1);
    else if (tick_mode == 0) frame_tick = 0;
    if (tick_mode != 3 && frame_tick) tick_cnt++;
  end

  // monitor: every move_done must match the oldest predicted board
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pos_y", pos_y, {10'd160, 10'd120});
      if (move_done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL move_done_unexpected actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_pos_x", pos_x, e.x);
          chk("done_tile_idx", tile_idx, e.t);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", move_ready, 0);
    end
    q.delete();
    for (int p = 0; p < NP; p++) mtile[p] = 0;
    mwin = 0; mid = 0;
    rst_n = 1;
    #1;
    chk("rst_pos_x", pos_x, {10'd20, 10'd20});
    chk("rst_tile", tile_idx, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_winner", winner_valid, 0);
  endtask

  task automatic do_move(input int p, input int s, input bit junk, output int bc);
    int n = 0;
    bc = 0;
    @(negedge clk);
    while (!move_ready && n < 200) begin @(negedge clk); n++; end
    if (!move_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    move_player = 1'(p); move_steps = 3'(s); move_valid = 1;
    if (p < NP) mtile[p] += (s < NT - 1 - mtile[p]) ? s : NT - 1 - mtile[p];
    q.push_back(mk());
    @(posedge clk); #1 move_valid = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 5000) break;
      bc++; n++;
      move_valid = junk && ($urandom_range(0, 3) == 0);
      move_player = 1'($urandom_range(0, 1));
      move_steps = 3'($urandom_range(1, 7));
      if (move_valid) chk("ready_while_busy", move_ready, 0);
    end
    move_valid = 0;
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL busy_timeout actual=%0d required=0", busy);
    end
    if (p < NP && mtile[p] == NT - 1 && !mwin) begin mwin = 1; mid = p; end
    chk("winner_valid", winner_valid, mwin);
    if (mwin) chk("winner_id", winner_id, mid);
  endtask

  initial begin
    int bc, n, prev_t, prev_x;
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, n, prev_t, prev_x;
    do_reset();

    // paced single move, checking tick counts per tile and 4-px steps
    @(negedge clk);
    move_valid = 1; move_player = 0; move_steps = 3;
    mtile[0] = 3; q.push_back(mk());
    @(posedge clk); #1 move_valid = 0;
    tick_ph = 0; tick_cnt = 0; tick_mode = 2;
    prev_t = 0; prev_x = 20; n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 4000) break;
      n++;
      if (int'(tile_idx[3:0]) != prev_t) begin
        prev_t = int'(tile_idx[3:0]);
        chk("ticks_per_tile", tick_cnt, 15 * prev_t);
      end
      if (int'(pos_x[9:0]) != prev_x) begin
        chk("x_step", int'(pos_x[9:0]) - prev_x, 4);
        prev_x = int'(pos_x[9:0]);
      end
    end
    chk("paced_final_x", pos_x[9:0], 200);
    chk("paced_final_tile", tile_idx[3:0], 3);
    tick_mode = 1;

    // zero-step move: one busy cycle, no motion
    do_move(1, 0, 0, bc);
    chk("zero_step_busy_cycles", bc, 1);

    // random play until someone wins, three times
    for (int r = 0; r < 3; r++) begin
      do_reset();
      tick_mode = 1;
      for (int k = 0; k < 60 && !mwin; k++)
        do_move($urandom_range(0, 1), $urandom_range(0, 7), 1, bc);
      chk("random_round_won", mwin, 1);
      @(negedge clk);
      move_valid = 1; move_player = 0; move_steps = 2;
      repeat (4) begin
        @(negedge clk);
        chk("ready_after_win", move_ready, 0);
      end
      move_valid = 0;
    end

    // finish clamp: 8 tiles, then 6 requested but only 2 taken
    do_reset();
    tick_mode = 1;
    do_move(1, 7, 0, bc);
    do_move(1, 1, 0, bc);
    do_move(1, 6, 0, bc);
    chk("clamp_x", pos_x[19:10], 620);
    chk("clamp_tile", tile_idx[7:4], 10);
    chk("clamp_winner_id", winner_id, 1);

    // reset while sliding at x=52
    do_reset();
    tick_mode = 3; frame_tick = 0;
    @(negedge clk);
    move_valid = 1; move_player = 0; move_steps = 2;
    @(posedge clk); #1 move_valid = 0;
    repeat (2) @(negedge clk);
    repeat (8) begin frame_tick = 1; @(negedge clk); end
    frame_tick = 0;
    @(negedge clk);
    chk("mid_slide_x", pos_x[9:0], 52);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_x", pos_x[9:0], 20);
    chk("mid_rst_tile", tile_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", move_done, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // non-dividing step: 7 px ticks saturate on tile 1
    t7_valid = 1; t7_player = 0; t7_steps = 1;
    @(posedge clk); #1 t7_valid = 0;
    repeat (2) @(negedge clk);
    repeat (8) begin t7_tick = 1; @(negedge clk); end
    t7_tick = 0;
    @(negedge clk);
    chk("px7_x_after_8", t7_x[9:0], 76);
    t7_tick = 1; @(negedge clk); t7_tick = 0;
    @(negedge clk);
    chk("px7_x_after_9", t7_x[9:0], 80);
    n = 0;
    while (t7_busy && n < 50) begin @(negedge clk); n++; end
    chk("px7_tile", t7_tile[3:0], 1);
    chk("px7_x_final", t7_x[9:0], 80);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
